// File: rtl/u_bam_pkg.sv
// Shared definitions for the broken-array multiplier accumulate datapaths.
// Width helpers are constant functions so later MAC/dot-product blocks size identically.
package u_bam_pkg;

    localparam int PROD_W_DEF = 16;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator wide enough that LEN full-scale products can never overflow.
    function automatic int acc_w(input int prod_w, input int len);
        return prod_w + clog2(len);
    endfunction

    function automatic int cnt_w(input int len);
        return clog2(len + 1);
    endfunction

endpackage

// File: rtl/u_bam_prod_acc.sv
// Frame accumulator: sums up to LEN unsigned products, closing a frame at LEN or at in_last.
// Latency: out_valid rises the cycle after the final accept; one dead input cycle per frame.
// Backpressure: result held in DONE until out_ready; in_ready is low for the whole DONE state.
module u_bam_prod_acc
    import u_bam_pkg::*;
#(
    parameter  int PROD_W = PROD_W_DEF,
    parameter  int LEN    = 8,
    localparam int ACC_W  = acc_w(PROD_W, LEN),
    localparam int CNT_W  = cnt_w(LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
);

    acc_state_t       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             frame_end;

    assign accept    = in_valid & in_ready;
    // in_last on the LEN-th product is still a single frame end.
    assign frame_end = in_last | (cnt == CNT_W'(LEN - 1));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            ACC: begin
                if (accept) begin
                    acc_nxt = acc + ACC_W'(in_prod);
                    cnt_nxt = cnt + CNT_W'(1);
                    if (frame_end) state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Handshakes and results are pure register decodes; nothing combinational from the ports.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = cnt;

endmodule
